store_buffer: RTL
=================

// Module: store_buffer
// PURPOSE
//  In-order posted-write buffer between the single-cycle core's data-store port (memwrite/dataadr/writedata)
//  and a slower data memory using a req/ack handshake. Accepts one store per cycle and stalls the core when full.
//  Drains stores to memory in program order. Forwards the youngest pending store data to same-address loads.
// PARAMETERS
//  DEPTH  4   entries; power of two, >=2
//  AW     32  address width
//  DW     32  data width
// PORTS
//  clk        in   1        core clock; all state updates on posedge
//  reset      in   1        synchronous, active-high
//  memwrite   in   1        core store strobe
//  dataadr    in   AW       store address (full compare, no alignment masking)
//  writedata  in   DW       store data
//  stall      out  1        memwrite & full (combinational); store not accepted this cycle
//  rd_en      in   1        core load strobe
//  rd_adr     in   AW       load address
//  fwd_hit    out  1        rd_en & some valid entry matches rd_adr (combinational)
//  fwd_data   out  DW       data of youngest matching entry; 0 when !fwd_hit
//  mem_req    out  1        registered; memory write request
//  mem_adr    out  AW       head entry address while mem_req
//  mem_wdata  out  DW       head entry data while mem_req
//  mem_ack    in   1        memory accepted head; ignored while !mem_req
//  empty      out  1        count==0
//  count      out  $clog2(DEPTH+1)  valid entries
// BEHAVIOUR
//  - Reset: count=0, empty=1, mem_req=0, mem_adr=0, mem_wdata=0, FSM=IDLE, pointers=0. Pending stores are discarded.
//  - Enqueue: memwrite & !full -> entry written at tail on this edge, visible (count, fwd) from next cycle.
//  - Full blocks enqueue even when mem_ack pops in the same cycle (stall=1, store dropped; core must hold and retry).
//  - Drain FSM:
//    - IDLE: mem_req=0. Leave when count>0 at the edge -> REQ, presenting the head.
//    - REQ: mem_req=1; mem_adr and mem_wdata held stable until mem_ack.
//    - On mem_ack: pop the head. If entries remain (counting a same-cycle enqueue), stay in REQ with the new head
//      next cycle (back-to-back). Otherwise -> IDLE (mem_req=0 next cycle).
//  - Simultaneous enqueue and pop (not full): count unchanged; ordering preserved.
//  - Forwarding:
//    - Combinational search over valid entries; youngest match wins.
//    - An entry being popped this cycle still forwards this cycle.
//    - A store being enqueued this cycle does not forward until next cycle.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. full = count==DEPTH.
//  - Reset mid-operation (mem_req high): the buffer is flushed at the edge; mem_ack arriving after reset is ignored.
// STRUCTURE
//  - store_buffer_defs.vh (shared include): FSM state localparams SB_IDLE=1'b0, SB_REQ=1'b1; default DEPTH/AW/DW.
//  - Sub-module sb_fifo_core:
//    - Holds the storage array, head/tail pointers, count and valid bits.
//    - Exposes push/pop, the head entry, and flattened entry/valid vectors for the forwarding search.
//  - The top level holds the drain FSM, stall, and the youngest-match priority search.
// TESTING (DEPTH=4)
//  1. Store adr=20, data=1000 for 1 cycle
//     -> next cycle: count=1, mem_req=1, mem_adr=20, mem_wdata=1000.
//     -> stable over 3 cycles with no ack; ack -> count=0, mem_req=0 next cycle.
//  2. Back-to-back stores adr 0,4,8,12,16 (data=adr+1), no ack
//     -> stall=1 on the 5th, count=4.
//     -> acks drain 0,4,8,12 in order, one per cycle back-to-back; 16 is never written.
//  3. Pending stores (20,1000) then (20,7); rd_en=1, rd_adr=20 -> fwd_hit=1, fwd_data=7.
//     rd_adr=24 -> fwd_hit=0, fwd_data=0.
//  4. count=1 in REQ; memwrite (8,55) with mem_ack in the same cycle
//     -> count stays 1; next cycle mem_req=1, mem_adr=8, mem_wdata=55.
//  5. count=4, memwrite and mem_ack in the same cycle -> stall=1, count=3, dropped store is never emitted.
//  6. count=3 with mem_req=1; assert reset for 1 cycle
//     -> count=0, empty=1, mem_req=0.
//     -> mem_ack pulse afterwards has no effect.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared constants for the store buffer: drain FSM state encodings and
// default geometry (entries, address width, data width).
package store_buffer_pkg;

    localparam logic [0:0] SB_IDLE = 1'b0;
    localparam logic [0:0] SB_REQ  = 1'b1;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 32;
    localparam int SB_DW    = 32;

endpackage

// File: rtl/sb_fifo_core.sv
// Circular storage for pending stores: address/data arrays, head and tail
// pointers, occupancy count and per-entry valid bits. Push is refused when
// full and pop is refused when empty, so callers may present raw strobes.
module sb_fifo_core
    import store_buffer_pkg::*;
#(
    parameter  int DEPTH = SB_DEPTH,
    parameter  int AW    = SB_AW,
    parameter  int DW    = SB_DW,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push_i,
    input  logic [AW-1:0]       pushAdr_i,
    input  logic [DW-1:0]       pushData_i,
    input  logic                pop_i,
    output logic [AW-1:0]       headAdr_o,
    output logic [DW-1:0]       headData_o,
    output logic [PW-1:0]       headPtr_o,
    output logic [CW-1:0]       count_o,
    output logic [CW-1:0]       countNext_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [DEPTH*AW-1:0] entryAdr_o,
    output logic [DEPTH*DW-1:0] entryData_o,
    output logic [DEPTH-1:0]    entryValid_o
);

    logic [AW-1:0]    adrMem_q  [DEPTH];
    logic [DW-1:0]    dataMem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic             pushEn;
    logic             popEn;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pushEn  = push_i & ~full_o;
    assign popEn   = pop_i & ~empty_o;

    // Next pointers, valid bits and count; push and pop never touch the same slot
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        count_d = count_q + CW'(pushEn) - CW'(popEn);
        if (popEn) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (pushEn) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end
    end

    // Bookkeeping registers; reset discards every pending entry
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload storage needs no reset because valid bits gate every use
    always_ff @(posedge clk) begin
        if (pushEn) begin
            adrMem_q[tail_q]  <= pushAdr_i;
            dataMem_q[tail_q] <= pushData_i;
        end
    end

    assign headAdr_o    = adrMem_q[head_q];
    assign headData_o   = dataMem_q[head_q];
    assign headPtr_o    = head_q;
    assign count_o      = count_q;
    assign countNext_o  = count_d;
    assign entryValid_o = valid_q;

    for (genvar g = 0; g < DEPTH; g++) begin : gPack
        assign entryAdr_o[g*AW +: AW]  = adrMem_q[g];
        assign entryData_o[g*DW +: DW] = dataMem_q[g];
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the core store port and a slow data memory.
// Stores are accepted one per cycle, drained in order over a req/ack
// handshake, and the youngest pending store forwards to same-address loads.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter  int DEPTH = SB_DEPTH,
    parameter  int AW    = SB_AW,
    parameter  int DW    = SB_DW,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwrite,
    input  logic [AW-1:0] dataadr,
    input  logic [DW-1:0] writedata,
    output logic          stall,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_adr,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data,
    output logic          mem_req,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [AW-1:0]       headAdr;
    logic [DW-1:0]       headData;
    logic [PW-1:0]       headPtr;
    logic [CW-1:0]       countNext;
    logic                full;
    logic [DEPTH*AW-1:0] entryAdrFlat;
    logic [DEPTH*DW-1:0] entryDataFlat;
    logic [DEPTH-1:0]    entryValid;
    logic [AW-1:0]       entryAdr  [DEPTH];
    logic [DW-1:0]       entryData [DEPTH];
    logic [0:0]          state_q, state_d;
    logic                pop;
    logic                matchHit;
    logic [DW-1:0]       matchData;
    logic [PW-1:0]       fwdIdx;

    sb_fifo_core #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) uFifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (memwrite),
        .pushAdr_i    (dataadr),
        .pushData_i   (writedata),
        .pop_i        (pop),
        .headAdr_o    (headAdr),
        .headData_o   (headData),
        .headPtr_o    (headPtr),
        .count_o      (count),
        .countNext_o  (countNext),
        .full_o       (full),
        .empty_o      (empty),
        .entryAdr_o   (entryAdrFlat),
        .entryData_o  (entryDataFlat),
        .entryValid_o (entryValid)
    );

    for (genvar g = 0; g < DEPTH; g++) begin : gUnpack
        assign entryAdr[g]  = entryAdrFlat[g*AW +: AW];
        assign entryData[g] = entryDataFlat[g*DW +: DW];
    end

    // A full buffer refuses the store even if the head drains this cycle
    assign stall = memwrite & full;

    assign mem_req   = (state_q == SB_REQ);
    assign pop       = mem_req & mem_ack;
    assign mem_adr   = mem_req ? headAdr  : '0;
    assign mem_wdata = mem_req ? headData : '0;

    // Drain FSM: request whenever the buffer will hold work after this edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            SB_IDLE: begin
                if (countNext != '0) state_d = SB_REQ;
            end
            SB_REQ: begin
                if (mem_ack) state_d = (countNext != '0) ? SB_REQ : SB_IDLE;
            end
            default: state_d = SB_IDLE;
        endcase
    end

    // Drain state register; reset abandons any outstanding request
    always_ff @(posedge clk) begin
        if (reset) state_q <= SB_IDLE;
        else       state_q <= state_d;
    end

    // Walk entries oldest to youngest so the last match is the youngest store
    always_comb begin
        matchHit  = 1'b0;
        matchData = '0;
        fwdIdx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwdIdx = headPtr + PW'(k);
            if (entryValid[fwdIdx] && (entryAdr[fwdIdx] == rd_adr)) begin
                matchHit  = 1'b1;
                matchData = entryData[fwdIdx];
            end
        end
    end

    assign fwd_hit  = rd_en & matchHit;
    assign fwd_data = fwd_hit ? matchData : '0;

endmodule
